// File: rtl/lsu_pkg.sv
// Shared state encoding, funct3 constants and size decode for the load/store access unit.
// The optional two-beat misaligned path is enabled by defining LSU_MISALIGN_SPLIT_EN.
package lsu_pkg;

  localparam int unsigned NBYTES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      2'b10:   size_of = 3'd4;
      default: size_of = 3'd0;
    endcase
  endfunction

  function automatic logic funct3_illegal(input logic [2:0] funct3);
    funct3_illegal = !(funct3 inside {LB, LH, LW, LBU, LHU, SB, SH, SW});
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Per-beat byte-lane mapping: byte enables, big-endian store lane placement and load gather.
// Beat 0 covers bytes landing in the first word, beat 1 the bytes that spill into the next word.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            offset,
  input  logic [2:0]            size,
  input  logic                  beat,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [NBYTES-1:0]     be,
  output logic [DATA_WIDTH-1:0] wlanes,
  output logic [DATA_WIDTH-1:0] rd_lanes,
  output logic [DATA_WIDTH-1:0] rd_keep
);

  // Byte k of the access sits at lane (offset+k) mod 4 of beat (offset+k)/4.
  always_comb begin
    be       = '0;
    wlanes   = '0;
    rd_lanes = '0;
    rd_keep  = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if ((3'(k) < size) && ((({1'b0, offset} + 3'(k)) >= 3'd4) == beat)) begin
        be[offset + 2'(k)]                         = 1'b1;
        wlanes[{offset + 2'(k), 3'b000} +: 8]      = wdata[{2'(size - 3'(k) - 3'd1), 3'b000} +: 8];
        rd_lanes[8*k +: 8]                         = rdata[{offset + 2'(k), 3'b000} +: 8];
        rd_keep[8*k +: 8]                          = 8'hFF;
      end
    end
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store access unit: turns byte-addressed requests into word beats with byte enables.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats; otherwise they are rejected.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rd,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [NBYTES-1:0]     mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  split_q, split_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  err_q, err_d;

  logic                  req_split, req_split_ok, req_reject;
  logic                  beat;
  logic [NBYTES-1:0]     beat_be;
  logic [DATA_WIDTH-1:0] beat_wlanes, beat_rd, beat_keep, rd_merged;
  logic [ADDR_WIDTH-1:0] beat_addr;

  assign req_split = ({1'b0, req_addr[1:0]} + size_of(req_funct3)) > 3'd4;

`ifdef LSU_MISALIGN_SPLIT_EN
  assign req_split_ok = req_split;
  assign req_reject   = funct3_illegal(req_funct3);
`else
  assign req_split_ok = 1'b0;
  assign req_reject   = funct3_illegal(req_funct3) | req_split;
`endif

  assign beat = (state_q == REQ1) || (state_q == WAIT1);

  lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
    .offset   (addr_q[1:0]),
    .size     (size_q),
    .beat     (beat),
    .wdata    (wdata_q),
    .rdata    (mem_rdata),
    .be       (beat_be),
    .wlanes   (beat_wlanes),
    .rd_lanes (beat_rd),
    .rd_keep  (beat_keep)
  );

  // Second beat targets the next word; the add wraps at the top of the address space.
  assign beat_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00} + (beat ? ADDR_WIDTH'(4) : ADDR_WIDTH'(0));
  assign rd_merged = (rd_q & ~beat_keep) | (beat_rd & beat_keep);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    split_d = split_q;
    rd_d    = rd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = size_of(req_funct3);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          split_d = req_split_ok;
          rd_d    = '0;
          err_d   = req_reject;
          state_d = req_reject ? RESP : REQ0;
        end
      end
      REQ0: begin
        if (mem_gnt) state_d = we_q ? (split_q ? REQ1 : RESP) : WAIT0;
      end
      WAIT0: begin
        if (mem_rvalid) begin
          rd_d    = rd_merged;
          state_d = split_q ? REQ1 : RESP;
        end
      end
      REQ1: begin
        if (mem_gnt) state_d = we_q ? RESP : WAIT1;
      end
      WAIT1: begin
        if (mem_rvalid) begin
          rd_d    = rd_merged;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      split_q <= 1'b0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      split_q <= split_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rd    = rd_q;
  assign resp_err   = err_q;
  assign mem_req    = (state_q == REQ0) || (state_q == REQ1);
  assign mem_we     = mem_req & we_q;
  assign mem_addr   = mem_req ? beat_addr : '0;
  assign mem_be     = mem_req ? beat_be : '0;
  assign mem_wdata  = mem_req ? beat_wlanes : '0;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: byte-level reference model, memory responder and response monitor.
// Honours LSU_MISALIGN_SPLIT_EN the same way as the design build.
module tb_lsu_mem_access;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  lsu_mem_access dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int unsigned acc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  resp_t exp_q[$];
  beat_t beat_q[$];
  logic [7:0] model_mem [logic [31:0]];
  logic [7:0] phys_mem  [logic [31:0]];

  int vectors = 0;
  int miscompares = 0;

  // Responder knobs
  int gnt_delay = 0;
  int rd_delay  = 0;
  bit rand_delays = 1'b0;
  bit spurious = 1'b0;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] model_get(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] phys_get(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_byte(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: observed %h (cycle %0d)", name, act, cyc);
  endtask

  // Reference model: byte k of the access is memory byte addr+k; stores are big-endian in wdata.
  task automatic model_push(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat, input int unsigned acc);
    int sz;
    bit illegal, split, err;
    resp_t r;
    beat_t b0, b1;
    logic [31:0] w0, ba;
    logic [1:0] lane;
    logic [7:0] bv;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    split = (int'(addr[1:0]) + sz) > 4;
    err = illegal || (split && !SPLIT);
    r.rd = '0;
    r.err = err;
    r.lat = lat;
    r.acc = acc;
    if (!err) begin
      w0 = addr & ~32'h3;
      b0 = '{addr: w0, be: 4'b0, we: we, wdata: 32'h0};
      b1 = '{addr: w0 + 32'd4, be: 4'b0, we: we, wdata: 32'h0};
      for (int k = 0; k < sz; k++) begin
        ba = addr + 32'(k);
        lane = ba[1:0];
        if (we) begin
          bv = wdata[8*(sz-1-k) +: 8];
          model_mem[ba] = bv;
        end else begin
          bv = 8'h00;
          r.rd[8*k +: 8] = model_get(ba);
        end
        if ((ba & ~32'h3) == w0) begin
          b0.be[lane] = 1'b1;
          b0.wdata[8*lane +: 8] = bv;
        end else begin
          b1.be[lane] = 1'b1;
          b1.wdata[8*lane +: 8] = bv;
        end
      end
      beat_q.push_back(b0);
      if (b1.be != 4'b0) beat_q.push_back(b1);
    end
    exp_q.push_back(r);
  endtask

  // Memory responder: checks each beat against the model, holds gnt/rvalid per knobs.
  initial begin
    bit in_beat = 1'b0;
    bit rd_pend = 1'b0;
    int gcnt = 0;
    int rcnt = 0;
    logic [31:0] rd_a = '0;
    beat_t cur;
    beat_t held;
    forever begin
      @(posedge clk);
      #1;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      if (rd_pend) begin
        if (rcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = {phys_get(rd_a + 32'd3), phys_get(rd_a + 32'd2), phys_get(rd_a + 32'd1), phys_get(rd_a)};
          rd_pend = 1'b0;
        end else begin
          rcnt--;
        end
      end else if (spurious && $urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'b1;
      end
      if (rst_n !== 1'b1) begin
        in_beat = 1'b0;
      end else if (mem_req === 1'b1) begin
        chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
        if (!in_beat) begin
          if (beat_q.size() == 0) begin
            fail_now("unexpected_beat", mem_addr);
          end else begin
            cur = beat_q.pop_front();
            chk("beat_addr", mem_addr, cur.addr);
            chk("beat_be", {28'b0, mem_be}, {28'b0, cur.be});
            chk("beat_we", {31'b0, mem_we}, {31'b0, cur.we});
            if (cur.we) chk("beat_wdata", mem_wdata, cur.wdata);
          end
          in_beat = 1'b1;
          held = '{addr: mem_addr, be: mem_be, we: mem_we, wdata: mem_wdata};
          gcnt = rand_delays ? int'($urandom_range(0, 3)) : gnt_delay;
        end else begin
          chk("hold_addr", mem_addr, held.addr);
          chk("hold_be", {28'b0, mem_be}, {28'b0, held.be});
          chk("hold_wdata", mem_wdata, held.wdata);
        end
        if (gcnt == 0) begin
          mem_gnt = 1'b1;
          in_beat = 1'b0;
          if (mem_we) begin
            for (int l = 0; l < 4; l++)
              if (mem_be[l]) phys_mem[mem_addr + 32'(l)] = mem_wdata[8*l +: 8];
          end else begin
            rd_pend = 1'b1;
            rd_a = mem_addr;
            rcnt = rand_delays ? int'($urandom_range(0, 3)) : rd_delay;
          end
        end else begin
          gcnt--;
        end
      end else begin
        if (in_beat) fail_now("mem_req_dropped", mem_addr);
        in_beat = 1'b0;
        if (spurious && $urandom_range(0, 3) == 0) mem_gnt = 1'b1;
      end
    end
  end

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_resp", resp_rd);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rd", resp_rd, e.rd);
          chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          if (e.lat >= 0) chk("latency", cyc - e.acc, 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat);
    int n;
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      fail_now("req_ready_timeout", {31'b0, req_ready});
      req_valid = 1'b0;
      return;
    end
    model_push(we, f3, addr, wdata, lat, cyc);
    @(negedge clk);
    req_valid = 1'b0;
    req_we = $urandom_range(0, 1);
    req_funct3 = 3'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || beat_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || beat_q.size() != 0)
      fail_now("drain_timeout", 32'(exp_q.size()));
    @(negedge clk);
  endtask

  task automatic set_knobs(input int gd, input int rdl, input bit rnd, input bit sp);
    gnt_delay = gd;
    rd_delay = rdl;
    rand_delays = rnd;
    spurious = sp;
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    model_mem[a] = v;
    phys_mem[a] = v;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rd", resp_rd, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Aligned lw, immediate gnt and rvalid
    set_knobs(0, 0, 1'b0, 1'b0);
    preload(32'h100, 8'h11);
    preload(32'h101, 8'h22);
    preload(32'h102, 8'h33);
    preload(32'h103, 8'h44);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 3);
    drain();

    issue(1'b1, 3'b000, 32'h103, 32'h000000AB, 2);
    drain();
    issue(1'b1, 3'b010, 32'h102, 32'hDEADBEEF, -1);
    drain();
    issue(1'b0, 3'b010, 32'h100, 32'h0, 3);
    drain();
    issue(1'b0, 3'b011, 32'h100, 32'h0, -1);
    drain();
    issue(1'b1, 3'b111, 32'h104, 32'h12345678, -1);
    drain();
    issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, -1);
    drain();
    issue(1'b0, 3'b001, 32'h0000_00FF, 32'h0, -1);
    drain();

    // lh with gnt withheld for 5 cycles
    set_knobs(5, 1, 1'b0, 1'b0);
    issue(1'b0, 3'b001, 32'h0000_00FE, 32'h0, -1);
    drain();

    // Reset while the load waits for rvalid; the late rvalid must be ignored
    set_knobs(0, 6, 1'b0, 1'b0);
    issue(1'b0, 3'b010, 32'h108, 32'h0, -1);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    beat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (10) @(negedge clk);
    set_knobs(0, 0, 1'b0, 1'b0);
    issue(1'b0, 3'b010, 32'h108, 32'h0, 3);
    drain();

    // Randomized traffic with random delays and stray gnt/rvalid
    set_knobs(0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else a = 32'h100 + 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, -1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
